uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter, the transmit-side counterpart of the core's `rx` block; shares its baud parameters and frame format (8N1, LSB first, idle high). Bytes are written through a strobe into a small FIFO, then shifted out on `tx` with exactly `CLK_COUNT_BIT` clocks per bit. It sits between the core's I/O write port and the board TX pin, and provides full/busy status plus an end-of-frame pulse.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `CLK_COUNT_BIT`, CLK_FREQ / BAUD_RATE (434), clocks per serial bit; must be ≥ 2
- `FIFO_DEPTH`, 4, entries in the transmit FIFO; power of two, ≥ 2
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `data`  in  8  byte to transmit
- `we`  in  1  write strobe; the byte is accepted on a rising edge where `we && !full`
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries; writes are dropped
- `tx`  out  1  serial line, registered
- `busy`  out  1  FIFO not empty or the FSM is not in IDLE
- `end_flag`  out  1  one-cycle pulse when a stop bit completes

## Operation
- Reset values: `tx`=1, `full`=0, `busy`=0, `end_flag`=0, FIFO empty, FSM=IDLE, bit counter=0, clock counter=0.
- FIFO: circular, write/read pointers of log2(FIFO_DEPTH) bits wrap naturally, occupancy counter 0..FIFO_DEPTH. `full` is registered from the occupancy. A write while full is dropped silently, even when a pop happens in the same cycle. A simultaneous write and pop leaves the occupancy unchanged.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, clear the clock counter, and go to START.
  - START: `tx`=0 for CLK_COUNT_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=shift[0] for CLK_COUNT_BIT cycles, then shift right and increment the index. After index 7, go to STOP (or PARITY, see Configuration).
  - STOP: `tx`=1 for CLK_COUNT_BIT cycles. On the last cycle, pulse `end_flag`. If the FIFO is non-empty, pop and go directly to START with no extra idle bit; otherwise go to IDLE.
- Clock counter: 32 bits, counts 0..CLK_COUNT_BIT-1, resets to 0 at each bit boundary. The bit boundary is the cycle where count == CLK_COUNT_BIT-1.
- `data` is sampled only at write time; later changes on `data` do not affect queued bytes.
- An `rst_n` assertion mid-frame forces `tx`=1 asynchronously, flushes the FIFO, and aborts the frame. No `end_flag` is produced.

## Timing
- A write accepted at edge E0 makes the FIFO non-empty after E0. IDLE pops at E0+1, so `tx` falls after E0+1: 2-cycle latency from `we` to the start bit.
- Frame length is 10×CLK_COUNT_BIT cycles (11× with parity). Back-to-back frames have no gap cycles.
- `end_flag` is high for exactly the single cycle following the last stop-bit clock edge.
- `full` deasserts one cycle after the pop that frees a slot.
- `busy` goes high the cycle after an accepted write. It goes low the cycle after STOP returns to IDLE with the FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity) for CLK_COUNT_BIT cycles.
  - The frame becomes 8E1, 11 bits.
- Not defined: no PARITY state; frame is 8N1, 10 bits; no parity logic is synthesized.

## Test plan
- Reset, then one write of 0xA5, with CLK_COUNT_BIT=8 → `tx` falls 2 cycles after `we`. The line reads 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. `end_flag` pulses once at cycle 80 of the frame. `busy` then drops.
- Five consecutive writes 0x01..0x05 with FIFO_DEPTH=4, while the first frame is active → all five are accepted. Five contiguous frames go out with no idle gap, and `end_flag` pulses 5 times.
- Six writes on consecutive cycles from idle → the first pops immediately and the next four fill the FIFO. `full`=1, the sixth byte (0x06) is dropped and never appears on `tx`.
- `rst_n` pulled low in the middle of DATA bit 3 → `tx`=1 immediately, `busy`=0, `full`=0. After release, no residual frame is sent.
- With `UART_TX_PARITY_EN` and write 0x07 → parity bit = 1, frame length 11×CLK_COUNT_BIT. With 0x03 → parity bit = 0.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : FIFO-buffered 8N1 UART transmitter, LSB first, idle high.
//            Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_COUNT_BIT = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       we,
  output logic       full,
  output logic       tx,
  output logic       busy,
  output logic       end_flag
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] CNT_LAST   = 32'(CLK_COUNT_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          end_flag_q, end_flag_d;
  logic          wr_en;
  logic          pop;
  logic          bit_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  always_comb begin
    wr_en      = we && !full_q;
    pop        = 1'b0;
    bit_done   = (cnt_q == CNT_LAST);
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    end_flag_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = 32'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d     = 32'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d     = 32'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = 32'd0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          cnt_d      = 32'd0;
          end_flag_d = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
    parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
`endif

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_FULL);

    // The line register follows the state being entered so tx is glitch-free.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      end_flag_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      end_flag_q <= end_flag_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign full     = full_q;
  assign tx       = tx_q;
  assign end_flag = end_flag_q;
  assign busy     = (count_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// Bench for uart_tx: writes are checked every cycle against a frame-timeline
// model (byte queue plus start time of the frame currently on the line).
module tb_uart_tx;

  localparam int C     = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'd0;
  logic       we    = 1'b0;
  logic       full, tx, busy, end_flag;

  uart_tx #(
    .CLK_FREQ      (80),
    .BAUD_RATE     (10),
    .CLK_COUNT_BIT (C),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .we       (we),
    .full     (full),
    .tx       (tx),
    .busy     (busy),
    .end_flag (end_flag)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] q[$];
  int         fs       = -1;
  int         cyc      = 0;
  logic [7:0] fbyte    = 8'd0;
  logic       exp_end  = 1'b0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
  endtask

  // Line level of frame bit k: start, 8 data bits LSB first, [parity], stop.
  function automatic logic exp_bit(input int k, input logic [7:0] b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] d);
    int qsz;
    qsz = q.size();
    cyc++;
    exp_end = 1'b0;
    if (fs >= 0 && cyc == fs + NB*C) begin
      exp_end = 1'b1;
      fs      = -1;
    end
    if (fs < 0 && qsz > 0) begin
      fbyte = q.pop_front();
      fs    = cyc;
    end
    if (w && qsz < DEPTH) q.push_back(d);
  endtask

  task automatic compare();
    logic etx;
    etx = (fs < 0) ? 1'b1 : exp_bit((cyc - fs) / C, fbyte);
    check("tx", tx, etx);
    check("busy", busy, (q.size() > 0) || (fs >= 0));
    check("full", full, q.size() == DEPTH);
    check("end_flag", end_flag, exp_end);
  endtask

  task automatic step(input logic w, input logic [7:0] d);
    we   = w;
    data = d;
    @(posedge clk);
    model_edge(w, d);
    #1;
    compare();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((fs >= 0 || q.size() > 0) && guard < 2000) begin
      step(1'b0, 8'($urandom));
      guard++;
    end
    check("drain_done", guard < 2000, 1'b1);
    repeat (5) step(1'b0, 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_end_flag", end_flag, 1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // Single byte, then five back-to-back, then six with the last one dropped.
    step(1'b1, 8'hA5);
    drain();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i));
    drain();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h01 + i));
    drain();
`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    drain();
`endif

    // Asynchronous reset in the middle of data bit 3 with a full FIFO.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h3C + i));
    guard = 0;
    while (!(fs >= 0 && cyc - fs == 4*C + 3) && guard < 200) begin
      step(1'b0, 8'($urandom));
      guard++;
    end
    check("reach_data_bit3", guard < 200, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_full", full, 1'b0);
    check("arst_end_flag", end_flag, 1'b0);
    q.delete();
    fs      = -1;
    exp_end = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (120) step(1'b0, 8'($urandom));

    // Random traffic: a heavy phase that saturates the FIFO, then a light one.
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) < 12, 8'($urandom));
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) < 1, 8'($urandom));
    drain();

    we = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
